// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one external bin2bcd converter among four requesters.
// Optional BCD_SCHED_SAT_EN: clamp operands to 99 and force the hundreds digit to zero.
module bcd_conv_sched #(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_bin,
  output logic [3:0]  req_ready,
  output logic [7:0]  conv_bin,
  input  logic [11:0] conv_bcd,
  output logic        rsp_valid,
  output logic [1:0]  rsp_id,
  output logic [11:0] rsp_bcd,
  output logic        busy
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned OP_W  = 8;
  localparam int unsigned BCD_W = 12;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   cur_idx;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   cand;
  logic               gnt_any;
  logic               accept;
  logic               settle_done;
  logic [CNT_W-1:0]   cnt;
  logic [OP_W-1:0]    gnt_op;
  logic [OP_W-1:0]    ld_op;
  logic [BCD_W-1:0]   cap_bcd;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = rr_ptr;
    cand    = rr_ptr;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      cand = rr_ptr + IDX_W'(k);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign gnt_op      = req_bin[{gnt_idx, 3'b000} +: OP_W];
  assign accept      = (state == IDLE) && gnt_any;
  assign settle_done = (state == SETTLE) && (cnt == '0);

`ifdef BCD_SCHED_SAT_EN
  assign ld_op   = (gnt_op > OP_W'(99)) ? OP_W'(99) : gnt_op;
  assign cap_bcd = {4'h0, conv_bcd[7:0]};
`else
  assign ld_op   = gnt_op;
  assign cap_bcd = conv_bcd;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_any) state_nxt = SETTLE;
      SETTLE:  if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Accept pulse is combinational so the operand is taken on the same cycle it is granted.
  always_comb begin
    req_ready = '0;
    if (accept && rst_n) req_ready[gnt_idx] = 1'b1;
  end

  // Operand, index, settle counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_bin  <= '0;
      cur_idx   <= '0;
      rr_ptr    <= IDX_W'(N_REQ - 1);
      cnt       <= '0;
      rsp_bcd   <= '0;
      rsp_id    <= '0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= settle_done;
      busy      <= (state_nxt != IDLE);
      if (accept) begin
        conv_bin <= ld_op;
        cur_idx  <= gnt_idx;
        rr_ptr   <= gnt_idx;
        cnt      <= CNT_W'(SETTLE_CYC - 1);
      end else if ((state == SETTLE) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (settle_done) begin
        rsp_bcd <= cap_bcd;
        rsp_id  <= cur_idx;
      end
    end
  end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Scoreboard bench for bcd_conv_sched: directed vectors, queued expectations, decoupled monitor.
// Honours BCD_SCHED_SAT_EN when computing expected operands and results.
module tb_bcd_conv_sched;

  localparam int unsigned S = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_bin;
  logic [3:0]  req_ready;
  logic [7:0]  conv_bin;
  logic [11:0] conv_bcd;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [11:0] rsp_bcd;
  logic        busy;

  logic        v4;
  logic [31:0] b4;
  logic [3:0]  rdy4;
  logic [7:0]  cb4;
  logic [11:0] cbcd4;
  logic        rv4;
  logic [1:0]  rid4;
  logic [11:0] rbcd4;
  logic        busy4;

  typedef struct packed {
    logic [1:0]  id;
    logic [11:0] bcd;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] bcd_of(input logic [7:0] x);
    return {4'(x / 8'd100), 4'((x / 8'd10) % 8'd10), 4'(x % 8'd10)};
  endfunction

  function automatic logic [7:0] sat_op(input logic [7:0] x);
`ifdef BCD_SCHED_SAT_EN
    return (x > 8'd99) ? 8'd99 : x;
`else
    return x;
`endif
  endfunction

  assign conv_bcd = bcd_of(conv_bin);
  assign cbcd4    = bcd_of(cb4);

  bcd_conv_sched #(.SETTLE_CYC(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_bin(req_bin),
    .req_ready(req_ready), .conv_bin(conv_bin), .conv_bcd(conv_bcd),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_bcd(rsp_bcd), .busy(busy)
  );

  bcd_conv_sched #(.SETTLE_CYC(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid({3'b000, v4}), .req_bin(b4),
    .req_ready(rdy4), .conv_bin(cb4), .conv_bcd(cbcd4),
    .rsp_valid(rv4), .rsp_id(rid4), .rsp_bcd(rbcd4), .busy(busy4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: pair each result with the queued expectation and its accept cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_q.delete();
    end else begin
      if ((req_valid & req_ready) != 4'b0000) acc_q.push_back(cyc);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_rsp");
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
          check("rsp_bcd", 32'(rsp_bcd), 32'(mon_e.bcd));
          if (acc_q.size() > 0) check("latency", 32'(cyc - acc_q.pop_front()), S + 1);
          else fail_now("latency_no_accept");
        end
      end
    end
  end

  task automatic drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 30) begin
      @(posedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      fail_now("rsp_timeout");
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  // Raise requests, expect grants in the order given by ids, then wait for all results.
  task automatic drive(input logic [3:0] mask, input logic [31:0] ops, input int n,
                       input logic [4:0][1:0] ids, input bit keep);
    int grants = 0;
    int last   = 0;
    int budget = 0;
    int idx;
    logic [3:0] g;
    logic [3:0] one = 4'b0001;
    logic [7:0] op;
    req_bin   = ops;
    req_valid = mask;
    for (int i = 0; i < n; i++) begin
      idx = int'(ids[i]);
      exp_q.push_back({ids[i], bcd_of(sat_op(ops[idx*8 +: 8]))});
    end
    while (grants < n && budget < 100) begin
      @(negedge clk);
      budget++;
      g = req_ready & req_valid;
      if (g != 4'b0000) begin
        check("grant", 32'(g), 32'(one << ids[grants]));
        if (grants > 0) check("spacing", 32'(cyc - last), S + 2);
        last = cyc;
        idx  = int'(ids[grants]);
        op   = ops[idx*8 +: 8];
        grants++;
        @(posedge clk); #1;
        if (grants == n) req_valid = 4'b0000;
        else if (!keep) req_valid = req_valid & ~g;
        @(negedge clk);
        check("conv_bin", 32'(conv_bin), 32'(sat_op(op)));
        check("busy_settle", 32'(busy), 1);
        check("ready_in_settle", 32'(req_ready), 0);
      end else begin
        @(posedge clk); #1;
      end
    end
    if (grants < n) fail_now("grant_timeout");
    req_valid = 4'b0000;
    drain();
  endtask

  task automatic wait_ready(input string name);
    int budget = 0;
    while (!(req_ready[0] && req_valid[0]) && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (budget == 20) fail_now(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_bin   = '0;
    v4        = 1'b0;
    b4        = '0;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_conv_bin", 32'(conv_bin), 0);
    check("rst_rsp_bcd", 32'(rsp_bcd), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // All four requesting continuously: 0,1,2,3,0.
    drive(4'b1111, {8'd78, 8'd56, 8'd34, 8'd12}, 5,
          {2'd0, 2'd3, 2'd2, 2'd1, 2'd0}, 1'b1);

    // Single request, operand 59.
    drive(4'b0001, 32'd59, 1, '0, 1'b0);

    // Requester 3 raised and withdrawn while busy: no grant, no result.
    req_bin   = {8'd200, 24'd42};
    req_valid = 4'b0001;
    exp_q.push_back({2'd0, bcd_of(sat_op(8'd42))});
    @(negedge clk);
    wait_ready("withdraw_accept_timeout");
    @(posedge clk); #1;
    req_valid = 4'b1000;
    @(negedge clk);
    check("ready_busy_withdraw", 32'(req_ready), 0);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    drain();
    repeat (4) @(posedge clk);
    #1;

    // Pointer left at 2, then 0 and 2 request: 0 first, then 2.
    drive(4'b0100, {8'd0, 8'd90, 16'd0}, 1, {2'd0, 2'd0, 2'd0, 2'd0, 2'd2}, 1'b0);
    drive(4'b0101, {8'd0, 8'd22, 8'd0, 8'd11}, 2, {2'd0, 2'd0, 2'd0, 2'd2, 2'd0}, 1'b0);

    // Reset during SETTLE of operand 200.
    req_bin   = 32'd200;
    req_valid = 4'b0001;
    @(negedge clk);
    wait_ready("reset_accept_timeout");
    @(posedge clk); #1;
    req_valid = 4'b0000;
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(req_ready), 0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_conv_bin", 32'(conv_bin), 0);
    check("mid_rst_rsp_bcd", 32'(rsp_bcd), 0);
    check("mid_rst_rsp_id", 32'(rsp_id), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_bin   = 32'd7;
    req_valid = 4'b0001;
    exp_q.push_back({2'd0, bcd_of(sat_op(8'd7))});
    @(negedge clk);
    check("first_arb", 32'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    drain();

    // Operand 255, saturated only when enabled.
    drive(4'b0001, 32'd255, 1, '0, 1'b0);

    // SETTLE_CYC=4 instance, operand 100.
    b4 = 32'd100;
    v4 = 1'b1;
    @(negedge clk);
    check("d4_ready", 32'(rdy4), 1);
    @(posedge clk); #1;
    v4 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("d4_busy", 32'(busy4), (k <= 5) ? 1 : 0);
      check("d4_rsp_valid", 32'(rv4), (k == 5) ? 1 : 0);
      if (k <= 5) check("d4_conv_bin", 32'(cb4), 32'(sat_op(8'd100)));
      if (k == 5) begin
        check("d4_rsp_bcd", 32'(rbcd4), 32'(bcd_of(sat_op(8'd100))));
        check("d4_rsp_id", 32'(rid4), 0);
      end
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_conv_sched.md
BCD_CONV_SCHED -- requirements
Module: bcd_conv_sched

Interface
REQ-001 Parameter: SETTLE_CYC, default 1, number of clk cycles the shared combinational bin2bcd converter is given to settle (legal 1..4).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  4  per-requester conversion request; bit i = requester i.
REQ-005 req_bin  input  32  packed operands; requester i uses bits [8i+7:8i].
REQ-006 req_ready  output  4  one-hot accept pulse; operand i sampled on the cycle req_valid[i] and req_ready[i] are both high.
REQ-007 conv_bin  output  8  registered operand driven to the external converter.
REQ-008 conv_bcd  input  12  converter result {hundreds, tens, units}.
REQ-009 rsp_valid  output  1  one-cycle result strobe.
REQ-010 rsp_id  output  2  requester index of the current result.
REQ-011 rsp_bcd  output  12  registered BCD result.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 FSM states: IDLE, SETTLE, RESP.
REQ-014 IDLE: when any req_valid is high, grant exactly one requester via round-robin, pulse its req_ready for one cycle, load req_bin slice into conv_bin, latch index, go to SETTLE.
REQ-015 Round-robin: search begins at (last granted + 1) mod 4; the requester granted receives lowest priority on the next arbitration.
REQ-016 SETTLE: hold conv_bin stable for exactly SETTLE_CYC cycles via down-counter, then go to RESP.
REQ-017 RESP: capture conv_bcd into rsp_bcd, drive rsp_id, pulse rsp_valid for one cycle, return to IDLE.
REQ-018 Latency: accept at cycle N; rsp_valid at cycle N+SETTLE_CYC+1; one conversion per SETTLE_CYC+2 cycles maximum.
REQ-019 req_ready never asserts outside IDLE; requests held during SETTLE/RESP wait, with no loss.
REQ-020 Deasserting req_valid[i] before its grant withdraws the request without side effect.
REQ-021 conv_bin and the latched index do not change between accept and the rsp_valid pulse.
REQ-022 rsp_bcd and rsp_id hold their value until the next RESP.
REQ-023 No back-pressure on the result; consumers must take rsp_valid on its cycle.

Reset
REQ-024 rst_n low asynchronously forces: state IDLE, req_ready 0, rsp_valid 0, busy 0, conv_bin 0, rsp_bcd 0, rsp_id 0, settle counter 0, round-robin pointer so requester 0 has highest priority.
REQ-025 Reset mid-conversion discards the operation; no rsp_valid is produced for it after reset release.
REQ-026 First arbitration is possible on the first rising edge with rst_n high.

Configuration
REQ-027 Macro BCD_SCHED_SAT_EN defined: operands above 99 are replaced by 99 when loaded into conv_bin, and rsp_bcd[11:8] is forced to 0.
REQ-028 Macro BCD_SCHED_SAT_EN undefined: operand passed unmodified (0..255), rsp_bcd = conv_bcd unmodified.

Verification
REQ-029 Single request: req_valid=4'b0001, req_bin[7:0]=8'd59, SETTLE_CYC=1 -> req_ready=0001 at N, rsp_valid at N+2, rsp_id=0, rsp_bcd=12'h059.
REQ-030 All four requesting continuously, operands 12/34/56/78 -> grants in order 0,1,2,3,0; results 12'h012,12'h034,12'h056,12'h078, each 3 cycles apart.
REQ-031 Pointer after grant to 2, then req_valid=4'b0101 -> requester 0 granted (search starts at 3), then 2.
REQ-032 rst_n low during SETTLE of operand 200 -> all outputs 0 immediately; no rsp_valid after release; next request 8'd7 returns 12'h007.
REQ-033 Operand 255: without BCD_SCHED_SAT_EN -> rsp_bcd=12'h255; with it -> conv_bin=8'd99, rsp_bcd=12'h099.
REQ-034 SETTLE_CYC=4, operand 8'd100 -> conv_bin stable 4 cycles, rsp_valid at N+5, busy high N+1..N+5.
